seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 81 ++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit seven-segment scanner with per-frame shadow latch and ghost blanking.
// Define SEG_SCAN_DIM_EN to add a 4-bit PWM brightness input.
module seg_scan_driver #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [27:0] display_in,
    input  logic [3:0]  dp_in,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       digit;
    logic [27:0]      shadow_seg;
    logic [3:0]       shadow_dp;
    logic             slot_end;
    logic             frame_end;
    logic             lit;
    logic [6:0]       cur_seg;

    assign slot_end  = slot_cnt == LAST;
    assign frame_end = slot_end && digit == 2'd3;
    assign cur_seg   = digit == 2'd0 ? shadow_seg[6:0]   :
                       digit == 2'd1 ? shadow_seg[13:7]  :
                       digit == 2'd2 ? shadow_seg[20:14] : shadow_seg[27:21];

`ifdef SEG_SCAN_DIM_EN
    // PWM phase restarts at the end of the ghosting guard
    logic [CNT_W+3:0] pwm_ofs;
    assign pwm_ofs = (CNT_W+4)'(slot_cnt) - (CNT_W+4)'(BLANK_CYCLES);
    assign lit     = slot_cnt >= BLANK && pwm_ofs[3:0] < brightness;
`else
    assign lit = slot_cnt >= BLANK;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt   <= '0;
            digit      <= 2'd0;
            shadow_seg <= '1;
            shadow_dp  <= 4'h0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            slot_cnt   <= '0;
            digit      <= 2'd0;
            shadow_seg <= display_in;
            shadow_dp  <= dp_in;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt   <= slot_end ? '0 : slot_cnt + 1'b1;
            digit      <= slot_end ? digit + 2'd1 : digit;
            // Latch only at the frame boundary so a frame never mixes two bus values
            if (frame_end) begin
                shadow_seg <= display_in;
                shadow_dp  <= dp_in;
            end
            frame_tick <= frame_end;
            an         <= lit ? ~(4'b0001 << digit) : 4'hF;
            seg        <= lit ? cur_seg : 7'h7F;
            dp         <= lit ? ~shadow_dp[digit] : 1'b1;
        end
    end
endmodule
